// File: rtl/all_men_in_detector.sv
// Arrival-accumulation detector: pulses all_men_in once every person has arrived.
// Ports: clk, rst_in (async high), men[N-1:0] strobes, all_men_in registered flag.
module all_men_in_detector #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_in,
  input  logic [N-1:0] men,
  output logic         all_men_in
);

  logic [N-1:0] seen_q;
  logic [N-1:0] seen_d;
  logic         all_men_in_q;
  logic         all_men_in_d;
  logic [N-1:0] acc;

  // Completion re-arms immediately, so a bit still high next
  // cycle counts toward the following group.
  always_comb begin
    acc          = seen_q | men;
    all_men_in_d = &acc;
    seen_d       = all_men_in_d ? '0 : acc;
  end

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      seen_q       <= '0;
      all_men_in_q <= 1'b0;
    end else begin
      seen_q       <= seen_d;
      all_men_in_q <= all_men_in_d;
    end
  end

  assign all_men_in = all_men_in_q;

endmodule

// File: tb/tb_all_men_in_detector.sv
// Scoreboard bench for all_men_in_detector.
// Directed strobe vectors with hand-computed expected flags.
module tb_all_men_in_detector;

  logic       clk;
  logic       rst_in;
  logic [3:0] men;
  logic       all_men_in;

  int n_checks;
  int n_fail;
  bit done;
  bit exp_q[$];

  all_men_in_detector #(.N(4)) dut (
    .clk        (clk),
    .rst_in     (rst_in),
    .men        (men),
    .all_men_in (all_men_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive on the falling edge; the flag is due after the next rising edge.
  task automatic drive(input logic [3:0] m, input bit e);
    @(negedge clk);
    men = m;
    exp_q.push_back(e);
  endtask

  task automatic check_now(input string name, input bit e);
    n_checks++;
    if (all_men_in !== e) begin
      n_fail++;
      $display("FAIL %s: got %b want %b at %0t", name, all_men_in, e,
               $time);
    end
  endtask

  // Pulse reset asynchronously in mid-cycle and check it clears at once.
  task automatic async_reset(input string name);
    @(posedge clk);
    #3;
    rst_in = 1'b1;
    #1;
    check_now(name, 1'b0);
    rst_in = 1'b0;
  endtask

  // Monitor: output is presented every cycle, compare after each edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        bit e;
        e = exp_q.pop_front();
        n_checks++;
        if (all_men_in !== e) begin
          n_fail++;
          $display("FAIL flag: got %b want %b at %0t", all_men_in, e,
                   $time);
        end
      end
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    men      = 4'b0000;
    rst_in   = 1'b1;
    #2;
    check_now("reset_async", 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_now("reset_hold", 1'b0);
    @(negedge clk);
    rst_in = 1'b0;

    // Single strobes in sequence
    drive(4'b0001, 1'b0);
    drive(4'b0010, 1'b0);
    drive(4'b0100, 1'b0);
    drive(4'b1000, 1'b1);
    // Carry-over bit 3, then completion on 0100
    drive(4'b1000, 1'b0);
    drive(4'b0011, 1'b0);
    drive(4'b0100, 1'b1);
    drive(4'b1000, 1'b0);
    drive(4'b0111, 1'b1);
    // Partial 0111 must not complete until 1000
    drive(4'b0111, 1'b0);
    drive(4'b1000, 1'b1);
    // Idle holds state, no pulse
    drive(4'b0000, 1'b0);
    drive(4'b0000, 1'b0);
    // All-at-once held: continuous high
    drive(4'b1111, 1'b1);
    drive(4'b1111, 1'b1);
    drive(4'b1111, 1'b1);
    drive(4'b0000, 1'b0);
    // Repeated strobe is sticky, single pulse
    drive(4'b0001, 1'b0);
    drive(4'b0001, 1'b0);
    drive(4'b0001, 1'b0);
    drive(4'b1110, 1'b1);
    drive(4'b0000, 1'b0);
    // Reset while flag high
    drive(4'b1111, 1'b1);
    async_reset("reset_clears_pulse");
    // Partial group discarded by mid-cycle reset
    drive(4'b0101, 1'b0);
    async_reset("reset_mid_group");
    drive(4'b1010, 1'b0);
    drive(4'b0101, 1'b1);
    drive(4'b0000, 1'b0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
